// File: rtl/axi_rr_arb_4_if.sv
`timescale 1ns / 1ps
// axi_rr_arb_4_if
// Bundles the four AXI-Stream source ports and the merged output port of the
// 4-way packet round-robin arbiter.
//   s0..s3_axis_*  : source streams (tvalid/tdata/tlast/tuser in, tready out)
//   m_axis_*       : merged stream (tvalid/tdata/tlast/tuser/tid out, tready in)
// Modports:
//   slave  : arbiter view (consumes sources, produces merged stream)
//   master : environment view (drives sources, consumes merged stream)
interface axi_rr_arb_4_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 8
);
  logic                   s0_axis_tvalid, s1_axis_tvalid, s2_axis_tvalid, s3_axis_tvalid;
  logic [DATA_WIDTH-1:0]  s0_axis_tdata,  s1_axis_tdata,  s2_axis_tdata,  s3_axis_tdata;
  logic                   s0_axis_tlast,  s1_axis_tlast,  s2_axis_tlast,  s3_axis_tlast;
  logic [TUSER_WIDTH-1:0] s0_axis_tuser,  s1_axis_tuser,  s2_axis_tuser,  s3_axis_tuser;
  logic                   s0_axis_tready, s1_axis_tready, s2_axis_tready, s3_axis_tready;

  logic                   m_axis_tvalid;
  logic [DATA_WIDTH-1:0]  m_axis_tdata;
  logic                   m_axis_tlast;
  logic [TUSER_WIDTH-1:0] m_axis_tuser;
  logic [1:0]             m_axis_tid;
  logic                   m_axis_tready;

  modport slave (
    input  s0_axis_tvalid, s1_axis_tvalid, s2_axis_tvalid, s3_axis_tvalid,
    input  s0_axis_tdata,  s1_axis_tdata,  s2_axis_tdata,  s3_axis_tdata,
    input  s0_axis_tlast,  s1_axis_tlast,  s2_axis_tlast,  s3_axis_tlast,
    input  s0_axis_tuser,  s1_axis_tuser,  s2_axis_tuser,  s3_axis_tuser,
    output s0_axis_tready, s1_axis_tready, s2_axis_tready, s3_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tid,
    input  m_axis_tready
  );

  modport master (
    output s0_axis_tvalid, s1_axis_tvalid, s2_axis_tvalid, s3_axis_tvalid,
    output s0_axis_tdata,  s1_axis_tdata,  s2_axis_tdata,  s3_axis_tdata,
    output s0_axis_tlast,  s1_axis_tlast,  s2_axis_tlast,  s3_axis_tlast,
    output s0_axis_tuser,  s1_axis_tuser,  s2_axis_tuser,  s3_axis_tuser,
    input  s0_axis_tready, s1_axis_tready, s2_axis_tready, s3_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tid,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_rr_arb_4.sv
`timescale 1ns / 1ps
// axi_rr_arb_4
// Four-source AXI-Stream packet arbiter. Whole packets are granted round-robin
// (search starts after the last source served); one bubble cycle per
// arbitration, then the granted source streams through a single output
// register stage at up to one beat per cycle.
// Ports:
//   clk         : clock, all state changes on rising edge
//   async_reset : asynchronous active-high reset (release synchronised inside)
//   axis        : axi_rr_arb_4_if.slave - four sources in, merged stream out
//                 (m_axis_tid carries the index of the producing source)
//   busy        : high while a packet grant is held
module axi_rr_arb_4 #(
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 8
) (
  input  logic          clk,
  input  logic          async_reset,
  axi_rr_arb_4_if.slave axis,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Returns {found, index}: first valid source searching last+1 .. last+4.
  // Iterating from the far end lets the nearest candidate overwrite.
  function automatic logic [2:0] rr_pick(input logic [3:0] vld, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + i[1:0];
      if (vld[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Assertion is immediate, release is aligned to clk through two flops.
  logic [1:0] rst_sync_p;
  logic       rst;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) rst_sync_p <= 2'b11;
    else             rst_sync_p <= {rst_sync_p[0], 1'b0};
  end

  assign rst = rst_sync_p[1];

  logic [3:0]             s_vld, s_last, s_rdy;
  logic [DATA_WIDTH-1:0]  s_data [4];
  logic [TUSER_WIDTH-1:0] s_user [4];

  assign s_vld  = {axis.s3_axis_tvalid, axis.s2_axis_tvalid, axis.s1_axis_tvalid, axis.s0_axis_tvalid};
  assign s_last = {axis.s3_axis_tlast,  axis.s2_axis_tlast,  axis.s1_axis_tlast,  axis.s0_axis_tlast};
  assign s_data[0] = axis.s0_axis_tdata;
  assign s_data[1] = axis.s1_axis_tdata;
  assign s_data[2] = axis.s2_axis_tdata;
  assign s_data[3] = axis.s3_axis_tdata;
  assign s_user[0] = axis.s0_axis_tuser;
  assign s_user[1] = axis.s1_axis_tuser;
  assign s_user[2] = axis.s2_axis_tuser;
  assign s_user[3] = axis.s3_axis_tuser;

  assign axis.s0_axis_tready = s_rdy[0];
  assign axis.s1_axis_tready = s_rdy[1];
  assign axis.s2_axis_tready = s_rdy[2];
  assign axis.s3_axis_tready = s_rdy[3];

  state_t     state_q, state_d;
  logic [1:0] g_q, g_d, last_q, last_d;
  logic [2:0] pick;
  logic       acc;

  logic                   vld_p1;
  logic [DATA_WIDTH-1:0]  data_p1;
  logic                   last_p1;
  logic [TUSER_WIDTH-1:0] user_p1;
  logic [1:0]             tid_p1;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    s_rdy   = '0;
    acc     = 1'b0;
    pick    = rr_pick(s_vld, last_q);
    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          g_d     = pick[1:0];
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Accept whenever the output register is empty or being drained.
        s_rdy[g_q] = ~vld_p1 | axis.m_axis_tready;
        acc        = s_vld[g_q] & s_rdy[g_q];
        if (acc && s_last[g_q]) begin
          last_d  = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
    end
  end

  // ---- output stage p1: one register, loads on accept, clears on drain ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      user_p1 <= '0;
      tid_p1  <= 2'd0;
    end else if (acc) begin
      vld_p1  <= 1'b1;
      data_p1 <= s_data[g_q];
      last_p1 <= s_last[g_q];
      user_p1 <= s_user[g_q];
      tid_p1  <= g_q;
    end else if (axis.m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign axis.m_axis_tvalid = vld_p1;
  assign axis.m_axis_tdata  = data_p1;
  assign axis.m_axis_tlast  = last_p1;
  assign axis.m_axis_tuser  = user_p1;
  assign axis.m_axis_tid    = tid_p1;
  assign busy               = (state_q == GRANT);

endmodule
